mont_exp_ctrl: RTL



---
 rtl/mont_exp_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// All operands stay in the Montgomery domain; one external Montgomery core
// is driven through a start-pulse / done-level handshake.
//
// Build option: define MONT_EXP_OUTCONV_EN to add a final multiply-by-one
// pass that converts the result out of the Montgomery domain. With the
// macro undefined the result is returned in Montgomery form.

module mont_exp_ctrl #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512,
    parameter int LEN_W     = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_one,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]     in_elen,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH-1:0]     mont_result,
    input  logic                 mont_done,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done
);

    // Index register only needs to address a bit of the exponent.
    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [LEN_W:0]     EXP_LIM  = (LEN_W+1)'(EXP_WIDTH);
    localparam logic [LEN_W:0]     LEN_ZERO = (LEN_W+1)'(0);
    localparam logic [LEN_W:0]     LEN_ONE  = (LEN_W+1)'(1);
    localparam logic [IDX_W-1:0]   IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
    localparam logic [EXP_WIDTH-1:0] E_ZERO = {EXP_WIDTH{1'b0}};
`ifdef MONT_EXP_OUTCONV_EN
    // Plain integer 1: multiplying by it strips one factor of R.
    localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD       = 4'd1,
        S_SQ_ISSUE   = 4'd2,
        S_SQ_WAIT    = 4'd3,
        S_MUL_ISSUE  = 4'd4,
        S_MUL_WAIT   = 4'd5,
        S_NEXT       = 4'd6,
        S_FINAL      = 4'd7,
        S_CONV_ISSUE = 4'd8,
        S_CONV_WAIT  = 4'd9,
        S_DONE       = 4'd10
    } state_t;

    state_t                 state_r;
    logic [WIDTH-1:0]       x_r;
    logic [WIDTH-1:0]       acc_r;
    logic [EXP_WIDTH-1:0]   e_r;
    logic [IDX_W-1:0]       idx_r;
    // Set during the first WAIT cycle: the core may still show the done
    // level of its previous operation, so that cycle never completes.
    logic                   first_r;

    logic [LEN_W:0]         elen_ext_s;
    logic [LEN_W:0]         elen_clip_s;
    logic [IDX_W-1:0]       idx_first_s;

    // Clamp the requested exponent length to the exponent register width.
    always_comb begin
        elen_ext_s = {1'b0, in_elen};
        if (elen_ext_s > EXP_LIM) begin
            elen_clip_s = EXP_LIM;
        end else begin
            elen_clip_s = elen_ext_s;
        end
        if (elen_clip_s == LEN_ZERO) begin
            idx_first_s = IDX_ZERO;
        end else begin
            idx_first_s = IDX_W'(elen_clip_s - LEN_ONE);
        end
    end

    // Main sequencer: state, datapath registers and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            x_r        <= W_ZERO;
            acc_r      <= W_ZERO;
            e_r        <= E_ZERO;
            idx_r      <= IDX_ZERO;
            first_r    <= 1'b0;
            mont_start <= 1'b0;
            mont_a     <= W_ZERO;
            mont_b     <= W_ZERO;
            mont_m     <= W_ZERO;
            result     <= W_ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        state_r <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    x_r    <= in_x;
                    mont_m <= in_m;
                    e_r    <= in_e;
                    acc_r  <= in_one;
                    if (elen_clip_s == LEN_ZERO) begin
                        state_r <= S_FINAL;
                    end else begin
                        idx_r   <= idx_first_s;
                        state_r <= S_SQ_ISSUE;
                    end
                end

                S_SQ_ISSUE: begin
                    mont_a     <= acc_r;
                    mont_b     <= acc_r;
                    mont_start <= 1'b1;
                    first_r    <= 1'b1;
                    state_r    <= S_SQ_WAIT;
                end

                S_SQ_WAIT: begin
                    mont_start <= 1'b0;
                    if (first_r) begin
                        first_r <= 1'b0;
                    end else if (mont_done) begin
                        acc_r <= mont_result;
                        if (e_r[idx_r]) begin
                            state_r <= S_MUL_ISSUE;
                        end else begin
                            state_r <= S_NEXT;
                        end
                    end
                end

                S_MUL_ISSUE: begin
                    mont_a     <= acc_r;
                    mont_b     <= x_r;
                    mont_start <= 1'b1;
                    first_r    <= 1'b1;
                    state_r    <= S_MUL_WAIT;
                end

                S_MUL_WAIT: begin
                    mont_start <= 1'b0;
                    if (first_r) begin
                        first_r <= 1'b0;
                    end else if (mont_done) begin
                        acc_r   <= mont_result;
                        state_r <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (idx_r == IDX_ZERO) begin
                        state_r <= S_FINAL;
                    end else begin
                        idx_r   <= idx_r - IDX_ONE;
                        state_r <= S_SQ_ISSUE;
                    end
                end

                S_FINAL: begin
`ifdef MONT_EXP_OUTCONV_EN
                    state_r <= S_CONV_ISSUE;
`else
                    result  <= acc_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_DONE;
`endif
                end

`ifdef MONT_EXP_OUTCONV_EN
                S_CONV_ISSUE: begin
                    mont_a     <= acc_r;
                    mont_b     <= W_ONE;
                    mont_start <= 1'b1;
                    first_r    <= 1'b1;
                    state_r    <= S_CONV_WAIT;
                end

                S_CONV_WAIT: begin
                    mont_start <= 1'b0;
                    if (first_r) begin
                        first_r <= 1'b0;
                    end else if (mont_done) begin
                        result  <= mont_result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    if (start) begin
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= S_LOAD;
                    end
                end

                default: begin
                    mont_start <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
